// File: rtl/framebuffer_arbiter_if.sv
`default_nettype none
// ============================================================================
// framebuffer_arbiter_if : requester/BRAM bundle for the framebuffer arbiter
// Rev 1.0
// ============================================================================
interface framebuffer_arbiter_if #(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 64
);
  logic                  rd_req_in;
  logic [ADDR_WIDTH-1:0] rd_addr_in;
  logic                  rd_grant_out;
  logic                  rd_valid_out;
  logic [DATA_WIDTH-1:0] rd_data_out;
  logic                  wr_req_in;
  logic [ADDR_WIDTH-1:0] wr_addr_in;
  logic [DATA_WIDTH-1:0] wr_data_in;
  logic                  wr_grant_out;
  logic [ADDR_WIDTH-1:0] bram_addr_out;
  logic [DATA_WIDTH-1:0] bram_din_out;
  logic                  bram_we_out;
  logic [DATA_WIDTH-1:0] bram_dout_in;
  logic [15:0]           conflict_count_out;
  logic                  starved_out;

  // Requesters plus the BRAM itself sit on the master side.
  modport master (
    output rd_req_in, rd_addr_in, wr_req_in, wr_addr_in, wr_data_in, bram_dout_in,
    input  rd_grant_out, rd_valid_out, rd_data_out, wr_grant_out,
           bram_addr_out, bram_din_out, bram_we_out, conflict_count_out, starved_out
  );

  modport slave (
    input  rd_req_in, rd_addr_in, wr_req_in, wr_addr_in, wr_data_in, bram_dout_in,
    output rd_grant_out, rd_valid_out, rd_data_out, wr_grant_out,
           bram_addr_out, bram_din_out, bram_we_out, conflict_count_out, starved_out
  );
endinterface
`default_nettype wire

// File: rtl/framebuffer_arbiter.sv
`default_nettype none
// ============================================================================
// framebuffer_arbiter : display-priority arbiter for the single-port framebuffer BRAM
// Rev 1.0
// ============================================================================
module framebuffer_arbiter #(
  parameter int ADDR_WIDTH      = 15,
  parameter int DATA_WIDTH      = 64,
  parameter int READ_LATENCY    = 2,
  parameter int WR_STARVE_LIMIT = 8
) (
  input wire                   clock_in,
  input wire                   reset_in,
  framebuffer_arbiter_if.slave bus
);
  localparam logic [7:0]  C_STARVE_LIMIT = 8'(WR_STARVE_LIMIT);
  localparam logic [15:0] C_CONFLICT_MAX = 16'hFFFF;

  typedef enum logic [0:0] {
    READ_PRIO      = 1'b0,
    WRITE_OVERRIDE = 1'b1
  } prio_t;

  logic [1:0]              rst_sync_q;
  prio_t                   prio_q;
  logic [7:0]              starve_q, starve_d;
  logic [15:0]             conflict_q, conflict_d;
  logic [ADDR_WIDTH-1:0]   bram_addr_q, bram_addr_d;
  logic [DATA_WIDTH-1:0]   bram_din_q, bram_din_d;
  logic                    bram_we_q;
  logic                    rd_issue_q;
  logic [READ_LATENCY-1:0] valid_q;
  logic [DATA_WIDTH-1:0]   rd_data_q;

  logic                    w_active;
  logic                    w_both;
  logic                    w_override;
  logic                    w_rd_grant;
  logic                    w_wr_grant;
  logic [READ_LATENCY:0]   w_chain;

  // Reset asserts immediately but releases two clocks later, so no grant
  // can be issued from a partially released state.
  always_ff @(posedge clock_in or negedge reset_in) begin
    if (!reset_in) rst_sync_q <= 2'b00;
    else           rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign w_active   = rst_sync_q[1];
  assign w_both     = bus.rd_req_in & bus.wr_req_in;
  assign w_override = w_active & w_both & (prio_q == WRITE_OVERRIDE);
  assign w_wr_grant = w_active & bus.wr_req_in & (~bus.rd_req_in | w_override);
  assign w_rd_grant = w_active & bus.rd_req_in & ~w_wr_grant;

  // Bit 0 is the issue flag, bit k is issue delayed by k cycles; the data
  // capture happens one stage before the valid strobe so both line up.
  assign w_chain = {valid_q, rd_issue_q};

  always_comb begin
    starve_d = '0;
    if (w_active && bus.wr_req_in && !w_wr_grant)
      starve_d = (starve_q == C_STARVE_LIMIT) ? starve_q : starve_q + 8'd1;

    conflict_d = conflict_q;
    if (w_active && w_both && (conflict_q != C_CONFLICT_MAX))
      conflict_d = conflict_q + 16'd1;

    bram_addr_d = bram_addr_q;
    bram_din_d  = bram_din_q;
    if (w_wr_grant) begin
      bram_addr_d = bus.wr_addr_in;
      bram_din_d  = bus.wr_data_in;
    end else if (w_rd_grant) begin
      bram_addr_d = bus.rd_addr_in;
    end
  end

  // The override state is simply "writer has been denied LIMIT cycles"; the
  // writer is always granted in that cycle, so it lasts exactly one cycle.
  always_ff @(posedge clock_in or negedge reset_in) begin
    if (!reset_in) begin
      prio_q      <= READ_PRIO;
      starve_q    <= '0;
      conflict_q  <= '0;
      bram_addr_q <= '0;
      bram_din_q  <= '0;
      bram_we_q   <= 1'b0;
      rd_issue_q  <= 1'b0;
      valid_q     <= '0;
      rd_data_q   <= '0;
    end else begin
      prio_q      <= (starve_d == C_STARVE_LIMIT) ? WRITE_OVERRIDE : READ_PRIO;
      starve_q    <= starve_d;
      conflict_q  <= conflict_d;
      bram_addr_q <= bram_addr_d;
      bram_din_q  <= bram_din_d;
      bram_we_q   <= w_wr_grant;
      rd_issue_q  <= w_rd_grant;
      valid_q     <= w_chain[READ_LATENCY-1:0];
      if (w_chain[READ_LATENCY-1])
        rd_data_q <= bus.bram_dout_in;
    end
  end

  assign bus.rd_grant_out       = w_rd_grant;
  assign bus.wr_grant_out       = w_wr_grant;
  assign bus.starved_out        = w_override;
  assign bus.rd_valid_out       = w_chain[READ_LATENCY];
  assign bus.rd_data_out        = rd_data_q;
  assign bus.bram_addr_out      = bram_addr_q;
  assign bus.bram_din_out       = bram_din_q;
  assign bus.bram_we_out        = bram_we_q;
  assign bus.conflict_count_out = conflict_q;
endmodule
`default_nettype wire

// File: tb/tb_framebuffer_arbiter.sv
`default_nettype none
// ============================================================================
// tb_framebuffer_arbiter : self-checking bench with write-first BRAM model
// Rev 1.0
// ============================================================================
module tb_framebuffer_arbiter;
  localparam int AW  = 15;
  localparam int DW  = 64;
  localparam int RL  = 2;
  localparam int LIM = 8;

  typedef struct {
    int          due;
    logic [63:0] data;
  } rd_exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  framebuffer_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  framebuffer_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(RL), .WR_STARVE_LIMIT(LIM)
  ) dut (
    .clock_in(clk),
    .reset_in(rst_n),
    .bus     (bus)
  );

  function automatic logic [63:0] init_word(input logic [14:0] a);
    return {8'h5A, 1'b0, a, 8'hC3, 1'b1, ~a, 16'(a) * 16'd3};
  endfunction

  // Write-first BRAM: address registered, data out on the following clock.
  logic [63:0] mem [logic [14:0]];
  always @(posedge clk) begin : bram_model
    logic [63:0] w;
    if (bus.bram_we_out) mem[bus.bram_addr_out] = bus.bram_din_out;
    w = mem.exists(bus.bram_addr_out) ? mem[bus.bram_addr_out] : init_word(bus.bram_addr_out);
    bus.bram_dout_in <= w;
  end

  initial begin
    #990000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic apply_reset();
    bus.rd_req_in = 1'b0;
    bus.wr_req_in = 1'b0;
    @(posedge clk); #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) @(posedge clk);
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    bus.rd_req_in = 1'b1;
    bus.wr_req_in = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({bus.rd_grant_out, bus.wr_grant_out, bus.starved_out} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_grants: got %b required 000", {bus.rd_grant_out, bus.wr_grant_out, bus.starved_out});
    end
    n_checks++;
    if ({bus.bram_we_out, bus.rd_valid_out, bus.bram_addr_out, bus.bram_din_out, bus.rd_data_out, bus.conflict_count_out} !== '0) begin
      n_fail++;
      $display("FAIL reset_regs: we=%b valid=%b addr=%h din=%h data=%h cnt=%h required all 0",
               bus.bram_we_out, bus.rd_valid_out, bus.bram_addr_out, bus.bram_din_out, bus.rd_data_out, bus.conflict_count_out);
    end
    bus.rd_req_in = 1'b0;
    bus.wr_req_in = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    // write then read 0x0010, reset lands while the read is in flight
    @(posedge clk); #1;
    bus.wr_req_in = 1'b1; bus.wr_addr_in = 15'h0010; bus.wr_data_in = 64'hDEAD_BEEF_0123_4567;
    @(negedge clk);
    n_checks++;
    if (bus.wr_grant_out !== 1'b1) begin
      n_fail++; $display("FAIL reset_pre_write_grant: got %b required 1", bus.wr_grant_out);
    end
    @(posedge clk); #1;
    bus.wr_req_in = 1'b0; bus.rd_req_in = 1'b1; bus.rd_addr_in = 15'h0010;
    @(negedge clk);
    n_checks++;
    if (bus.rd_grant_out !== 1'b1) begin
      n_fail++; $display("FAIL reset_pre_read_grant: got %b required 1", bus.rd_grant_out);
    end
    @(posedge clk); #1;
    bus.rd_req_in = 1'b0;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.bram_we_out, bus.rd_valid_out, bus.bram_addr_out, bus.bram_din_out} !== '0) begin
      n_fail++;
      $display("FAIL reset_midread_regs: we=%b valid=%b addr=%h din=%h required all 0",
               bus.bram_we_out, bus.rd_valid_out, bus.bram_addr_out, bus.bram_din_out);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_checks++;
      if (bus.rd_valid_out !== 1'b0) begin
        n_fail++; $display("FAIL reset_discard_valid: cycle %0d got %b required 0", i, bus.rd_valid_out);
      end
    end
  endtask

  task automatic test_single_read();
    @(posedge clk); #1;
    bus.wr_req_in = 1'b1; bus.wr_addr_in = 15'h1234; bus.wr_data_in = 64'h00AB_CD12_3456_7890;
    @(posedge clk); #1;
    bus.wr_req_in = 1'b0;
    @(posedge clk); #1;
    bus.rd_req_in = 1'b1; bus.rd_addr_in = 15'h1234;
    @(negedge clk);
    n_checks++;
    if ({bus.rd_grant_out, bus.wr_grant_out} !== 2'b10) begin
      n_fail++; $display("FAIL single_grant: got %b required 10", {bus.rd_grant_out, bus.wr_grant_out});
    end
    @(posedge clk); #1;
    bus.rd_req_in = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.bram_addr_out !== 15'h1234 || bus.bram_we_out !== 1'b0 || bus.rd_valid_out !== 1'b0) begin
      n_fail++;
      $display("FAIL single_port: addr=%h we=%b valid=%b required 1234/0/0", bus.bram_addr_out, bus.bram_we_out, bus.rd_valid_out);
    end
    @(negedge clk);
    n_checks++;
    if (bus.rd_valid_out !== 1'b0) begin
      n_fail++; $display("FAIL single_early_valid: got %b required 0", bus.rd_valid_out);
    end
    @(negedge clk);
    n_checks++;
    if (bus.rd_valid_out !== 1'b1 || bus.rd_data_out !== 64'h00AB_CD12_3456_7890) begin
      n_fail++;
      $display("FAIL single_return: valid=%b data=%h required 1/00abcd1234567890", bus.rd_valid_out, bus.rd_data_out);
    end
    @(negedge clk);
    n_checks++;
    if (bus.rd_valid_out !== 1'b0 || bus.rd_data_out !== 64'h00AB_CD12_3456_7890) begin
      n_fail++;
      $display("FAIL single_hold: valid=%b data=%h required 0/00abcd1234567890", bus.rd_valid_out, bus.rd_data_out);
    end
  endtask

  task automatic test_pipelined_reads();
    logic [63:0] exp_d;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      bus.rd_req_in  = (i < 4);
      bus.rd_addr_in = 15'(i);
      @(negedge clk);
      n_checks++;
      if (bus.rd_grant_out !== (i < 4)) begin
        n_fail++; $display("FAIL pipe_grant: cycle %0d got %b", i, bus.rd_grant_out);
      end
      if (i >= 3 && i <= 6) begin
        exp_d = init_word(15'(i - 3));
        n_checks++;
        if (bus.rd_valid_out !== 1'b1 || bus.rd_data_out !== exp_d) begin
          n_fail++;
          $display("FAIL pipe_return: cycle %0d valid=%b data=%h required 1/%h", i, bus.rd_valid_out, bus.rd_data_out, exp_d);
        end
      end else begin
        n_checks++;
        if (bus.rd_valid_out !== 1'b0) begin
          n_fail++; $display("FAIL pipe_idle_valid: cycle %0d got %b required 0", i, bus.rd_valid_out);
        end
      end
    end
  endtask

  task automatic test_write();
    localparam logic [63:0] D = 64'hFFFF_FFFF_0000_00FF;
    @(posedge clk); #1;
    bus.wr_req_in = 1'b1; bus.wr_addr_in = 15'h7FFF; bus.wr_data_in = D;
    @(negedge clk);
    n_checks++;
    if ({bus.rd_grant_out, bus.wr_grant_out} !== 2'b01) begin
      n_fail++; $display("FAIL write_grant: got %b required 01", {bus.rd_grant_out, bus.wr_grant_out});
    end
    @(posedge clk); #1;
    bus.wr_req_in = 1'b0; bus.rd_req_in = 1'b1; bus.rd_addr_in = 15'h7FFF;
    @(negedge clk);
    n_checks++;
    if (bus.bram_we_out !== 1'b1 || bus.bram_addr_out !== 15'h7FFF || bus.bram_din_out !== D || bus.rd_grant_out !== 1'b1) begin
      n_fail++;
      $display("FAIL write_port: we=%b addr=%h din=%h rdg=%b required 1/7fff/%h/1",
               bus.bram_we_out, bus.bram_addr_out, bus.bram_din_out, bus.rd_grant_out, D);
    end
    @(posedge clk); #1;
    bus.rd_req_in = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.bram_we_out !== 1'b0 || bus.bram_din_out !== D) begin
      n_fail++; $display("FAIL write_one_shot: we=%b din=%h required 0/%h", bus.bram_we_out, bus.bram_din_out, D);
    end
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (bus.rd_valid_out !== 1'b1 || bus.rd_data_out !== D) begin
      n_fail++; $display("FAIL write_readback: valid=%b data=%h required 1/%h", bus.rd_valid_out, bus.rd_data_out, D);
    end
  endtask

  task automatic test_starvation();
    logic [2:0] exp_g;
    apply_reset();
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      bus.rd_req_in = 1'b1; bus.wr_req_in = 1'b1;
      bus.rd_addr_in = 15'(i); bus.wr_addr_in = 15'h4000 + 15'(i);
      bus.wr_data_in = {$urandom, $urandom};
      @(negedge clk);
      exp_g = (i == 9 || i == 18) ? 3'b011 : 3'b100;
      n_checks++;
      if ({bus.rd_grant_out, bus.wr_grant_out, bus.starved_out} !== exp_g) begin
        n_fail++;
        $display("FAIL starve_grant: cycle %0d rd/wr/starved=%b required %b", i,
                 {bus.rd_grant_out, bus.wr_grant_out, bus.starved_out}, exp_g);
      end
    end
    @(posedge clk); #1;
    bus.rd_req_in = 1'b0; bus.wr_req_in = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.conflict_count_out !== 16'd20) begin
      n_fail++; $display("FAIL starve_conflicts: got %0d required 20", bus.conflict_count_out);
    end
    repeat (6) @(posedge clk);
  endtask

  task automatic test_random();
    rd_exp_t     q[$];
    rd_exp_t     e;
    logic [63:0] model_mem [logic [14:0]];
    logic        r, w, ewr, erd, est, prev_wr;
    logic [14:0] ra, wa;
    logic [63:0] wd;
    int          mstarve, exp_cnt;
    mstarve = 0; exp_cnt = 0; prev_wr = 1'b0;
    apply_reset();
    for (int i = 0; i < 405; i++) begin
      @(posedge clk); #1;
      r  = (i < 400) && ($urandom_range(0, 99) < 60);
      w  = (i < 400) && ($urandom_range(0, 99) < 55);
      ra = 15'($urandom_range(0, 15));
      wa = 15'($urandom_range(0, 15));
      wd = {$urandom, $urandom};
      bus.rd_req_in = r; bus.rd_addr_in = ra;
      bus.wr_req_in = w; bus.wr_addr_in = wa; bus.wr_data_in = wd;
      // display wins ties unless the writer has already lost LIM cycles running
      est = r && w && (mstarve == LIM);
      ewr = w && (!r || est);
      erd = r && !ewr;
      @(negedge clk);
      n_checks++;
      if ({bus.rd_grant_out, bus.wr_grant_out, bus.starved_out, bus.bram_we_out} !== {erd, ewr, est, prev_wr}) begin
        n_fail++;
        $display("FAIL rand_arb: cycle %0d rd/wr/starved/we=%b required %b", i,
                 {bus.rd_grant_out, bus.wr_grant_out, bus.starved_out, bus.bram_we_out}, {erd, ewr, est, prev_wr});
      end
      if (q.size() > 0 && q[0].due == cyc) begin
        e = q.pop_front();
        n_checks++;
        if (bus.rd_valid_out !== 1'b1 || bus.rd_data_out !== e.data) begin
          n_fail++;
          $display("FAIL rand_return: cycle %0d valid=%b data=%h required 1/%h", i, bus.rd_valid_out, bus.rd_data_out, e.data);
        end
      end else begin
        n_checks++;
        if (bus.rd_valid_out !== 1'b0) begin
          n_fail++; $display("FAIL rand_spurious_valid: cycle %0d got %b required 0", i, bus.rd_valid_out);
        end
      end
      if (erd) begin
        e.due  = cyc + 1 + RL;
        e.data = model_mem.exists(ra) ? model_mem[ra] : init_word(ra);
        q.push_back(e);
      end
      if (ewr) model_mem[wa] = wd;
      mstarve = (w && !ewr) ? ((mstarve < LIM) ? mstarve + 1 : mstarve) : 0;
      exp_cnt += int'(r && w);
      prev_wr = ewr;
    end
    n_checks++;
    if (bus.conflict_count_out !== 16'(exp_cnt)) begin
      n_fail++; $display("FAIL rand_conflicts: got %0d required %0d", bus.conflict_count_out, exp_cnt);
    end
  endtask

  task automatic test_conflict_saturation();
    apply_reset();
    @(posedge clk); #1;
    bus.rd_req_in = 1'b1; bus.wr_req_in = 1'b1;
    bus.rd_addr_in = 15'h0100; bus.wr_addr_in = 15'h0200; bus.wr_data_in = 64'h1;
    repeat (65534) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (bus.conflict_count_out !== 16'hFFFE) begin
      n_fail++; $display("FAIL sat_before: got %h required fffe", bus.conflict_count_out);
    end
    @(negedge clk);
    n_checks++;
    if (bus.conflict_count_out !== 16'hFFFF) begin
      n_fail++; $display("FAIL sat_reach: got %h required ffff", bus.conflict_count_out);
    end
    repeat (4465) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (bus.conflict_count_out !== 16'hFFFF) begin
      n_fail++; $display("FAIL sat_nowrap: got %h required ffff", bus.conflict_count_out);
    end
    @(posedge clk); #1;
    bus.rd_req_in = 1'b0; bus.wr_req_in = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  initial begin
    bus.rd_req_in  = 1'b0;
    bus.rd_addr_in = '0;
    bus.wr_req_in  = 1'b0;
    bus.wr_addr_in = '0;
    bus.wr_data_in = '0;
    test_reset();
    test_single_read();
    test_pipelined_reads();
    test_write();
    test_starvation();
    test_random();
    test_conflict_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/framebuffer_arbiter.md
Name: framebuffer_arbiter

Overview:
Shares the single-port 64-bit framebuffer BRAM between two requesters. The display reader fetches point records and has priority. The network writer stores incoming point records. The block does per-cycle arbitration, registers the BRAM port, tracks read latency to return tagged read data, and has a starvation guard so a continuously requesting display cannot lock out frame uploads.

Parameters:
ADDR_WIDTH, 15, BRAM address width (32768 records)
DATA_WIDTH, 64, BRAM word width (x[55:40], y[39:24], b/g/r[23:0]; upper byte reserved)
READ_LATENCY, 2, BRAM clock-to-douta latency in cycles (1..4)
WR_STARVE_LIMIT, 8, consecutive denied writer cycles before writer wins one grant (2..255)

Ports:
clock_in  input  1  system clock
reset_in  input  1  asynchronous, active-low reset
rd_req_in  input  1  display read request, held until granted
rd_addr_in  input  ADDR_WIDTH  read address, valid with rd_req_in
rd_grant_out  output  1  combinational; read accepted this cycle
rd_valid_out  output  1  one-cycle strobe; rd_data_out valid
rd_data_out  output  DATA_WIDTH  returned read word
wr_req_in  input  1  writer request, held until granted
wr_addr_in  input  ADDR_WIDTH  write address
wr_data_in  input  DATA_WIDTH  write word
wr_grant_out  output  1  combinational; write accepted this cycle
bram_addr_out  output  ADDR_WIDTH  registered BRAM address
bram_din_out  output  DATA_WIDTH  registered BRAM write data
bram_we_out  output  1  registered BRAM write enable
bram_dout_in  input  DATA_WIDTH  BRAM read data
conflict_count_out  output  16  saturating count of cycles with both requests high
starved_out  output  1  high for the one cycle in which the writer wins by starvation override

Behaviour:
- Reset (reset_in low, asynchronous): the following clear to 0 immediately:
  - bram_addr_out, bram_din_out, bram_we_out
  - rd_valid_out, rd_data_out
  - conflict_count_out, starve counter, latency pipeline
- Grants are 0 while in reset. Reads in flight at reset are discarded and never produce rd_valid_out. Deassertion is synchronised internally by a 2-flop release.
- Arbitration (combinational, cycle N):
  - Only rd_req_in high: rd_grant_out=1.
  - Only wr_req_in high: wr_grant_out=1.
  - Both high: read wins unless starve_cnt == WR_STARVE_LIMIT, in which case write wins and starved_out=1.
  - At most one grant is high per cycle.
- Starve counter (8-bit):
  - Increments on each cycle with wr_req_in=1 and wr_grant_out=0.
  - Saturates at WR_STARVE_LIMIT.
  - Clears on wr_grant_out=1 or wr_req_in=0.
- BRAM port (registered at end of cycle N):
  - Granted read: bram_addr_out=rd_addr_in, bram_we_out=0.
  - Granted write: bram_addr_out=wr_addr_in, bram_din_out=wr_data_in, bram_we_out=1.
  - No grant: bram_we_out=0; bram_addr_out and bram_din_out hold their previous values.
- Read return:
  - A READ_LATENCY-deep valid shift register is fed by the registered read-issue flag.
  - rd_valid_out pulses in cycle N+1+READ_LATENCY (3 cycles after grant at default).
  - rd_data_out is registered from bram_dout_in in that same cycle and holds until the next valid.
  - Back-to-back read grants give back-to-back valids, in order, fully pipelined.
- Write-then-read to the same address in consecutive cycles returns the new data; the BRAM is configured write-first and the arbiter adds no bypass.
- conflict_count_out increments on each cycle with both requests high and saturates at 16'hFFFF.
- No internal FSM beyond the arbitration priority, which has two states:
  - READ_PRIO (default): read wins ties.
  - WRITE_OVERRIDE: entered only for the single cycle where starve_cnt == WR_STARVE_LIMIT; returns to READ_PRIO unconditionally on the next cycle.
- A grant is only issued when the corresponding request is high; requesters may drop requests at any time without side effects.

Test Plan:
- Reset mid-read: grant a read to addr 0x0010, assert reset_in low 1 cycle later -> rd_valid_out never pulses; all BRAM outputs read 0 after reset.
- Single read: rd_req_in with addr 0x1234, BRAM model returns 64'h00AB_CD12_3456_7890 -> rd_grant_out same cycle; bram_addr_out=0x1234 next cycle; rd_valid_out with that data exactly 3 cycles after grant.
- Pipelined reads: addrs 0,1,2,3 on consecutive cycles -> four consecutive rd_valid_out pulses with data in order.
- Write: wr_req_in addr 0x7FFF, data 64'hFFFF_FFFF_0000_00FF -> wr_grant_out same cycle; bram_we_out=1 for exactly one cycle next cycle; a following read of 0x7FFF returns that data.
- Starvation: hold both requests high for 20 cycles with WR_STARVE_LIMIT=8 -> write granted on cycle 9 with starved_out=1, then again on cycle 18; reads on all other cycles; conflict_count_out=20.
- Conflict saturation: force both requests high for 70000 cycles -> conflict_count_out stops at 16'hFFFF and does not wrap.
